// File: rtl/fpu_issue_ctl.sv
`default_nettype none
// ============================================================================
// Module      : fpu_issue_ctl
// Description : Execute-side initiator for the FPU execute slave. Presents one
//               decoded FPU micro-op for a single cycle, drives the FPU hold
//               from its HOLD status, and turns the returned result into a
//               one-cycle FPR writeback or SR.T update. Results are squashed
//               when a branch flush arrives while an op is in flight.
//               Optional hold watchdog: define FPU_ISSUE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_issue_ctl #(
    parameter logic [5:0] UCMD_NOP    = 6'h00,
    parameter logic [5:0] UCMD_FCMP   = 6'h0D,
    parameter int         CNT_W       = 5,
    parameter int         TIMEOUT_CYC = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_cmd,
    input  logic [7:0]       in_ixt,
    input  logic [5:0]       in_rs,
    input  logic [5:0]       in_rt,
    input  logic [5:0]       in_rn,
    input  logic [63:0]      in_vals,
    input  logic [63:0]      in_valt,
    input  logic             flush,
    output logic [7:0]       fpu_cmd,
    output logic [7:0]       fpu_ixt,
    output logic [5:0]       fpu_rs,
    output logic [5:0]       fpu_rt,
    output logic [5:0]       fpu_rn,
    output logic [63:0]      fpu_vals,
    output logic [63:0]      fpu_valt,
    output logic             fpu_flush,
    output logic             fpu_hold,
    input  logic [1:0]       fpu_ok,
    input  logic [63:0]      fpu_val,
    input  logic [5:0]       fpu_id,
    input  logic             fpu_srt,
    output logic             wb_valid,
    output logic [5:0]       wb_id,
    output logic [63:0]      wb_val,
    output logic             srt_valid,
    output logic             srt,
    output logic             busy,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    localparam logic [1:0] c_OK_READY = 2'b00;
    localparam logic [1:0] c_OK_OK    = 2'b01;
    localparam logic [1:0] c_OK_HOLD  = 2'b10;

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam logic c_TO_EN = 1'b1;
`else
    localparam logic c_TO_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] c_TO_CNT  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_is_cmp;
    logic             r_squash;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_accept;
    logic             w_busy;
    logic             w_hold_st;
    logic             w_timeout;

    // Handshake and hold decode; the hold is the one output allowed to follow
    // the FPU status combinationally so the FPU sees it in the same cycle.
    always_comb begin
        w_busy    = (r_state != S_IDLE);
        in_ready  = (r_state == S_IDLE) || (r_state == S_WB);
        busy      = w_busy;
        w_accept  = in_valid && in_ready && !flush;
        w_hold_st = (r_state == S_WAIT) && (fpu_ok == c_OK_HOLD);
        w_timeout = c_TO_EN && w_hold_st && (r_hold_cnt == c_TO_CNT);
        fpu_hold  = w_hold_st && !w_timeout;
    end

    // Next-state decode for the issue sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_timeout)                w_state_nxt = S_IDLE;
                else if (fpu_ok == c_OK_HOLD) w_state_nxt = S_WAIT;
                else if (fpu_ok == c_OK_OK)   w_state_nxt = S_WB;
                else                          w_state_nxt = S_IDLE;
            end
            S_WB:    w_state_nxt = w_accept ? S_ISSUE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Command, status capture and strobe registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            fpu_cmd     <= {2'b00, UCMD_NOP};
            fpu_ixt     <= '0;
            fpu_rs      <= '0;
            fpu_rt      <= '0;
            fpu_rn      <= '0;
            fpu_vals    <= '0;
            fpu_valt    <= '0;
            fpu_flush   <= 1'b0;
            wb_valid    <= 1'b0;
            wb_id       <= '0;
            wb_val      <= '0;
            srt_valid   <= 1'b0;
            srt         <= 1'b0;
            err_timeout <= 1'b0;
            r_is_cmp    <= 1'b0;
            r_squash    <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            // The command is only non-NOP for the single ISSUE cycle.
            fpu_cmd     <= {2'b00, UCMD_NOP};
            wb_valid    <= 1'b0;
            srt_valid   <= 1'b0;
            err_timeout <= w_timeout;
            // One flush pulse per squashed op; a watchdog drop also flushes.
            fpu_flush   <= (w_busy && flush && !r_squash) || w_timeout;

            if (w_accept) begin
                fpu_cmd    <= in_cmd;
                fpu_ixt    <= in_ixt;
                fpu_rs     <= in_rs;
                fpu_rt     <= in_rt;
                fpu_rn     <= in_rn;
                fpu_vals   <= in_vals;
                fpu_valt   <= in_valt;
                r_is_cmp   <= (in_cmd[5:0] == UCMD_FCMP);
                r_hold_cnt <= '0;
            end else if (w_hold_st && !w_timeout && (r_hold_cnt != c_CNT_MAX)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            if (w_accept || (w_state_nxt == S_IDLE)) r_squash <= 1'b0;
            else if (w_busy && flush)               r_squash <= 1'b1;

            // A flush arriving with the OK status squashes that same result.
            if ((r_state == S_WAIT) && (fpu_ok == c_OK_OK)) begin
                wb_id     <= fpu_id;
                wb_val    <= fpu_val;
                srt       <= fpu_srt;
                wb_valid  <= !r_is_cmp && !r_squash && !flush;
                srt_valid <= r_is_cmp && !r_squash && !flush;
            end
        end
    end

    assign hold_cnt = r_hold_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fpu_issue_ctl
// Description : Directed self-checking bench for fpu_issue_ctl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_ctl;

    localparam logic [1:0] RDY  = 2'b00;
    localparam logic [1:0] OK   = 2'b01;
    localparam logic [1:0] HOLD = 2'b10;
    localparam logic [1:0] FLT  = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_cmd;
    logic [7:0]  in_ixt;
    logic [5:0]  in_rs, in_rt, in_rn;
    logic [63:0] in_vals, in_valt;
    logic        flush;
    logic [7:0]  fpu_cmd;
    logic [7:0]  fpu_ixt;
    logic [5:0]  fpu_rs, fpu_rt, fpu_rn;
    logic [63:0] fpu_vals, fpu_valt;
    logic        fpu_flush;
    logic        fpu_hold;
    logic [1:0]  fpu_ok;
    logic [63:0] fpu_val;
    logic [5:0]  fpu_id;
    logic        fpu_srt;
    logic        wb_valid;
    logic [5:0]  wb_id;
    logic [63:0] wb_val;
    logic        srt_valid;
    logic        srt;
    logic        busy;
    logic [4:0]  hold_cnt;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;
    int n;
    int bad;

    always #5 clock = ~clock;

    fpu_issue_ctl dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cmd(in_cmd), .in_ixt(in_ixt),
        .in_rs(in_rs), .in_rt(in_rt), .in_rn(in_rn),
        .in_vals(in_vals), .in_valt(in_valt),
        .flush(flush),
        .fpu_cmd(fpu_cmd), .fpu_ixt(fpu_ixt),
        .fpu_rs(fpu_rs), .fpu_rt(fpu_rt), .fpu_rn(fpu_rn),
        .fpu_vals(fpu_vals), .fpu_valt(fpu_valt),
        .fpu_flush(fpu_flush), .fpu_hold(fpu_hold),
        .fpu_ok(fpu_ok), .fpu_val(fpu_val), .fpu_id(fpu_id), .fpu_srt(fpu_srt),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
        .srt_valid(srt_valid), .srt(srt),
        .busy(busy), .hold_cnt(hold_cnt), .err_timeout(err_timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [7:0] cmd, input logic [5:0] rn);
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_ixt   = 8'h00;
        in_rs    = rn + 6'd1;
        in_rt    = rn + 6'd2;
        in_rn    = rn;
        in_vals  = 64'h3FF0_0000_0000_0000;
        in_valt  = 64'h4000_0000_0000_0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_cmd = '0; in_ixt = '0;
        in_rs = '0; in_rt = '0; in_rn = '0; in_vals = '0; in_valt = '0;
        flush = 1'b0; fpu_ok = RDY; fpu_val = '0; fpu_id = '0; fpu_srt = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_cmd",   fpu_cmd, 8'h00);
        check("rst_busy",  busy, 1'b0);
        check("rst_wb",    {wb_valid, srt_valid, fpu_flush, err_timeout}, 4'b0000);
        check("rst_ready", in_ready, 1'b1);
        reset = 1'b0;
        tick();

        // 1: FADD, 5 HOLD cycles then OK
        offer(8'h01, 6'h12); #1;
        check("t1_ready", in_ready, 1'b1);
        tick(); in_valid = 1'b0; #1;
        check("t1_issue_cmd", fpu_cmd, 8'h01);
        check("t1_issue_rn",  fpu_rn, 6'h12);
        check("t1_issue_st",  {busy, in_ready}, 2'b10);
        tick(); fpu_ok = HOLD; #1;
        check("t1_cmd_nop", fpu_cmd, 8'h00);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (fpu_hold) n++;
            tick();
        end
        check("t1_hold_cycles", n, 5);
        fpu_ok = OK; fpu_val = 64'h4008_0000_0000_0000; fpu_id = 6'h12; #1;
        check("t1_hold_cnt", hold_cnt, 5'd5);
        check("t1_hold_off", fpu_hold, 1'b0);
        tick(); fpu_ok = RDY; #1;
        check("t1_wb_valid", {wb_valid, srt_valid}, 2'b10);
        check("t1_wb_id",    wb_id, 6'h12);
        check("t1_wb_val",   wb_val, 64'h4008_0000_0000_0000);
        tick(); #1;
        check("t1_after", {wb_valid, busy}, 2'b00);

        // 2: FCMP, 1 HOLD then OK with SR.T=1
        offer(8'h0D, 6'h05);
        tick(); in_valid = 1'b0;
        tick(); fpu_ok = HOLD; #1;
        check("t2_hold", fpu_hold, 1'b1);
        tick(); fpu_ok = OK; fpu_srt = 1'b1; fpu_id = 6'h05; fpu_val = 64'h1;
        tick(); fpu_ok = RDY; fpu_srt = 1'b0; #1;
        check("t2_strobes", {srt_valid, srt, wb_valid}, 3'b110);
        tick(); #1;
        check("t2_after", {srt_valid, busy}, 2'b00);

        // 3: condition-false op, FPU answers READY
        offer(8'h81, 6'h07);
        tick(); in_valid = 1'b0; fpu_ok = RDY;
        tick(); #1;
        check("t3_busy_wait", busy, 1'b1);
        tick(); #1;
        check("t3_idle", {busy, in_ready, wb_valid, srt_valid}, 4'b0100);

        // 4: flush on the 2nd HOLD cycle of a 4-cycle FMUL
        offer(8'h02, 6'h09);
        tick(); in_valid = 1'b0;
        tick(); fpu_ok = HOLD; #1;
        check("t4_hold1", fpu_hold, 1'b1);
        tick(); flush = 1'b1; #1;
        check("t4_hold2", {fpu_hold, fpu_flush}, 2'b10);
        tick(); flush = 1'b0; #1;
        check("t4_flush_pulse", {fpu_hold, fpu_flush}, 2'b11);
        tick(); #1;
        check("t4_flush_once", {fpu_hold, fpu_flush}, 2'b10);
        tick(); fpu_ok = OK; fpu_id = 6'h09; fpu_val = 64'h77;
        tick(); fpu_ok = RDY; #1;
        check("t4_no_wb", {wb_valid, srt_valid}, 2'b00);
        tick(); #1;
        check("t4_idle", busy, 1'b0);

        // 5: back-to-back, second op offered in WB
        offer(8'h01, 6'h21);
        tick(); in_valid = 1'b0;
        tick(); fpu_ok = OK; fpu_id = 6'h21; fpu_val = 64'hAAAA;
        tick(); fpu_ok = RDY; offer(8'h03, 6'h22); #1;
        check("t5_wb1", {wb_valid, in_ready}, 2'b11);
        check("t5_wb1_id", wb_id, 6'h21);
        tick(); in_valid = 1'b0; #1;
        check("t5_issue2_cmd", fpu_cmd, 8'h03);
        check("t5_issue2", {fpu_rn, wb_valid, busy}, {6'h22, 1'b0, 1'b1});
        tick(); fpu_ok = OK; fpu_id = 6'h22; fpu_val = 64'hBBBB;
        tick(); fpu_ok = RDY; #1;
        check("t5_wb2", {wb_valid, wb_id}, {1'b1, 6'h22});
        check("t5_wb2_val", wb_val, 64'hBBBB);
        tick(); #1;
        check("t5_idle", {busy, wb_valid}, 2'b00);

        // 6: HOLD held indefinitely
        offer(8'h04, 6'h30);
        tick(); in_valid = 1'b0;
        tick(); fpu_ok = HOLD; #1;
`ifdef FPU_ISSUE_TIMEOUT_EN
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            if (!fpu_hold || err_timeout) bad++;
            tick();
        end
        check("t6_hold_phase", bad, 0);
        check("t6_drop_hold", {fpu_hold, hold_cnt}, {1'b0, 5'd24});
        tick(); fpu_ok = RDY; #1;
        check("t6_timeout", {err_timeout, fpu_flush, busy, wb_valid}, 4'b1100);
        tick(); #1;
        check("t6_pulse_end", {err_timeout, fpu_flush}, 2'b00);
`else
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy || !fpu_hold || err_timeout) bad++;
            tick();
        end
        check("t6_persist", bad, 0);
        check("t6_sat", hold_cnt, 5'd31);
        fpu_ok = FLT;
        tick(); fpu_ok = RDY; #1;
        check("t6_fault", {busy, wb_valid, srt_valid}, 3'b000);
`endif

        // 7: accept with flush discards the op
        offer(8'h01, 6'h11); flush = 1'b1;
        tick(); in_valid = 1'b0; flush = 1'b0; #1;
        check("t7_discard", {busy, fpu_cmd}, {1'b0, 8'h00});

        // 8: reset mid-op aborts with no strobes
        offer(8'h01, 6'h13);
        tick(); in_valid = 1'b0;
        tick(); fpu_ok = HOLD; reset = 1'b1;
        tick(); reset = 1'b0; fpu_ok = OK; #1;
        check("t8_reset", {busy, fpu_hold, hold_cnt}, {1'b0, 1'b0, 5'd0});
        tick(); fpu_ok = RDY; #1;
        check("t8_no_strobe", {wb_valid, srt_valid, busy}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_issue_ctl.md
Name: fpu_issue_ctl

Overview:
Initiator-side controller in the main Execute unit that drives the FPU execute slave.
- Accepts one decoded FPU micro-op at a time from the EX1 front end and presents it to the FPU for exactly one cycle.
- Generates the FPU hold from the FPU's HOLD status and collects the result or SR.T.
- Emits a single-cycle FPR writeback or SR.T update, and squashes results on branch flush.

Parameters:
UCMD_NOP, 6'h00, opcode driven on fpu_cmd[5:0] when no op is issued
UCMD_FCMP, 6'h0D, opcode whose result is SR.T rather than an FPR write
CNT_W, 5, width of hold-cycle counter
TIMEOUT_CYC, 24, hold-cycle limit used by the optional watchdog

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  micro-op offered
in_ready  out  1  micro-op accepted this cycle when in_valid&in_ready
in_cmd  in  8  [7:6] cond code, [5:0] opcode
in_ixt  in  8  opcode extension
in_rs / in_rt / in_rn  in  6 each  register ids
in_vals / in_valt  in  64 each  operand values
flush  in  1  branch flush
fpu_cmd  out  8  command to FPU
fpu_ixt  out  8  extension to FPU
fpu_rs / fpu_rt / fpu_rn  out  6 each  register ids to FPU
fpu_vals / fpu_valt  out  64 each  operands to FPU
fpu_flush  out  1  flush to FPU
fpu_hold  out  1  exHold to FPU
fpu_ok  in  2  FPU status: 00 READY, 01 OK, 10 HOLD, 11 FAULT
fpu_val  in  64  FPU result
fpu_id  in  6  FPU destination id
fpu_srt  in  1  FPU SR.T result
wb_valid  out  1  FPR writeback strobe
wb_id  out  6  writeback id
wb_val  out  64  writeback value
srt_valid  out  1  SR.T update strobe
srt  out  1  SR.T value
busy  out  1  op in flight
hold_cnt  out  CNT_W  hold cycles of current op
err_timeout  out  1  watchdog pulse

Behaviour:
- Reset (synchronous, active-high) while reset=1 at a clock edge:
  - state=IDLE.
  - fpu_cmd = {2'b00, UCMD_NOP}.
  - All other outputs 0, and the squash flag is cleared.
  - Reset during any state aborts the op with no strobes.
- States: IDLE, ISSUE, WAIT, WB. All fpu_* outputs are registered.
- in_ready = 1 in IDLE and WB, and 0 in ISSUE and WAIT.
- Accept (in_valid&in_ready, flush=0):
  - Register all in_* onto fpu_*, record is_cmp = (in_cmd[5:0]==UCMD_FCMP), go to ISSUE.
  - Accept with flush=1 discards the op and stays in or returns to IDLE.
- ISSUE (1 cycle): the FPU latches the command at the end of this cycle. On the next edge, fpu_cmd is set to NOP and the state goes to WAIT.
- WAIT:
  - fpu_hold = (fpu_ok==HOLD), combinational; this is the only combinational output.
  - HOLD: stay in WAIT, hold_cnt+1, saturating at its maximum.
  - OK: capture fpu_val, fpu_id and fpu_srt, go to WB.
  - READY (condition false or NOP): go to IDLE with no strobe.
  - FAULT: go to IDLE with no strobe.
- WB (1 cycle):
  - is_cmp=0: wb_valid=1 with the captured id and value.
  - is_cmp=1: srt_valid=1 with the captured SR.T.
  - A new accept in WB goes directly to ISSUE; otherwise the state goes to IDLE.
- busy = state != IDLE.
- hold_cnt clears on each accept.
- Flush while in ISSUE/WAIT/WB:
  - Sets squash; fpu_flush=1 for one cycle.
  - The op still runs to a non-HOLD status, with fpu_hold still honoured.
  - wb_valid/srt_valid are suppressed while squash is set; squash clears on return to IDLE or on a new accept.
  - Flush in ISSUE turns the next fpu_cmd into NOP immediately.
- Strobes never exceed one cycle.
- No new command is presented to the FPU while fpu_hold=1.

Optional Feature:
FPU_ISSUE_TIMEOUT_EN.
- Defined: in WAIT, when hold_cnt reaches TIMEOUT_CYC with fpu_ok still HOLD:
  - err_timeout pulses for 1 cycle, the op is dropped with no strobe, and fpu_hold deasserts.
  - fpu_flush pulses for 1 cycle and the state returns to IDLE.
- Undefined: no watchdog; WAIT persists for as long as the FPU reports HOLD, and err_timeout is tied 0.

Test Plan:
1. FADD (cmd 8'h0? with ixt 0, Rn=6'h12), FPU returns HOLD for 5 cycles then OK with val 64'h4008_0000_0000_0000 -> fpu_cmd non-NOP for exactly 1 cycle; fpu_hold high 5 cycles; hold_cnt=5; single wb_valid with wb_id=12, wb_val=4008...; no srt_valid.
2. FCMP with FPU returning OK and srt=1 after 1 HOLD cycle -> srt_valid=1, srt=1, wb_valid=0.
3. Conditional-false op with FPU returning READY -> no strobes; busy drops 2 cycles after accept; in_ready returns to 1.
4. flush asserted on the 2nd HOLD cycle of a 4-cycle FMUL -> fpu_flush pulses once, fpu_hold follows HOLD, no wb_valid, back in IDLE afterwards.
5. Two ops back-to-back with the second offered during WB -> accepted in WB; second ISSUE on the cycle after WB; two distinct wb_valid pulses with the correct ids.
6. With FPU_ISSUE_TIMEOUT_EN, TIMEOUT_CYC=24 and HOLD held forever -> err_timeout pulses after 24 HOLD cycles, no wb_valid, IDLE; with the macro undefined, busy stays 1 for 100 cycles.
